cb_circuit_ctrl: RTL and testbench
==================================

// Module: cb_circuit_ctrl
// PURPOSE
//  Sequencer for the 8-segment commutator buffer (cb_circuit) in the 64-point FFT datapath.
//  Drives the buffer's per-segment hold_seg_0..7 and shared select, and wraps it in valid/ready.
//  Mode 0 (GATHER): 8 serial words on lane D0 -> one parallel frame on Q0..Q7.
//  Mode 1 (SCATTER): one parallel frame on D0..D7 -> 8 serial words on Q0.
// PARAMETERS
//  NSEG   8  number of buffer segments; beat counter and decoder are sized from it
//  SEL_W  4  select width, clog2(NSEG+1); 0 = shift from segment above, k+1 = load D<k>
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  mode       in   1      0 = GATHER, 1 = SCATTER; sampled only in IDLE
//  in_valid   in   1      upstream word/frame valid
//  in_ready   out  1      upstream accept
//  out_valid  out  1      downstream word/frame valid (data is the buffer's Q outputs)
//  out_ready  in   1      downstream accept
//  out_last   out  1      last beat of the frame
//  hold_seg   out  NSEG   per-segment hold, bit k -> hold_seg_k; 1 = segment keeps its value
//  seg_sel    out  SEL_W  shared segment select -> in_ctrl_all_seg
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Registered state: FSM {IDLE, GATHER, GFULL, SLOAD, SSHIFT}, 3-bit beat counter cnt, mode_q.
//  - All outputs decode combinationally from state, cnt and handshake inputs (same-cycle enables into the buffer).
//  - No combinational path from in_valid to in_ready.
//  - Reset (async, any state): state=IDLE, cnt=0, mode_q=0.
//    Outputs: hold_seg=all 1s, seg_sel=0, in_ready=0, out_valid=0, out_last=0, busy=0.
//    Buffer contents are not touched by this block.
//  - Default outside the listed cases: hold_seg=all 1s, seg_sel=0.
//  - IDLE: in_ready=0, no data accepted. If in_valid=1: mode_q<=mode, cnt<=0.
//    Next state is GATHER (mode=0) or SLOAD (mode=1).
//  - GATHER: in_ready=1, seg_sel=1 (lane D0), hold_seg[cnt]=~in_valid, all other segments held.
//    On accept, cnt++. Accept at cnt=7 -> GFULL, cnt<=0.
//  - GFULL: out_valid=1, out_last=1, all segments held. Frame is on Q0..Q7, with the first word on Q0.
//    On out_ready -> IDLE.
//  - SLOAD: seg_sel=cnt+1, hold_seg[cnt]=~in_valid. in_ready=(cnt==7).
//    Source keeps D0..D7 stable while in_valid=1 and in_ready=0 (standard rule), so one frame beat loads over 8 cycles.
//    in_valid=1 & cnt<7: cnt++. in_valid=0: pause, cnt held, nothing written.
//    in_valid=1 & cnt==7: beat accepted -> SSHIFT, cnt<=0.
//  - SSHIFT: out_valid=1, seg_sel=0, hold_seg=all ~out_ready, out_last=(cnt==7). Serial word is on Q0.
//    On out_ready: cnt++, buffer shifts toward segment 0 and segment 7 fills with 0.
//    Accept at cnt==7 -> IDLE. The buffer ends all-zero.
//  - Backpressure: out_ready=0 freezes the buffer and cnt. out_valid stays high and the data stays stable.
//  - A mode change while busy is ignored until the next IDLE. Minimum gap between frames: 1 IDLE cycle.
//  - Throughput: GATHER 8+1+1 cycles per frame, SCATTER 8+8+1 cycles per frame (no stalls).
//  - Invariant: at most one hold_seg bit is 0 in GATHER/SLOAD. seg_sel is never > NSEG.
// STRUCTURE
//  - Shared package cb_pkg: state enum, CB_SEL_SHIFT=0, CB_SEL_LOAD0=1, NSEG default.
//  - One sub-module: cb_hold_decoder (cnt, en -> active-low one-hot hold vector, all 1s when en=0).
//  - Top-level cb_ctrl_top instantiates cb_circuit_ctrl + cb_circuit. Hold bits map one-to-one to hold_seg_k.
// TESTING
//  - Reset: assert rst mid-SSHIFT at cnt=4 -> outputs immediately hold_seg=8'hFF, seg_sel=0, out_valid=0, busy=0.
//    After release, state is IDLE.
//  - GATHER: mode=0, feed 0x0..0x7 on D0 with in_valid=1, out_ready=1.
//    -> Q0..Q7 = 0x0..0x7, out_valid=out_last=1 for 1 cycle, busy falls 1 cycle later.
//  - GATHER with gaps: drop in_valid on beats 2 and 5 -> cnt holds, no segment is written, frame is still 0x0..0x7.
//  - SCATTER: mode=1, D0..D7=0xA0..0xA7 held with in_valid=1.
//    -> in_ready high only on the 8th load cycle. Q0 emits 0xA0..0xA7 on 8 consecutive cycles, out_last on 0xA7.
//    -> Afterwards Q0..Q7 = 0.
//  - SCATTER backpressure: out_ready=0 for 3 cycles after word 2 -> Q0 stays 0xA2, hold_seg=8'hFF.
//    The sequence resumes with no loss or duplication.
//  - Mode toggled while busy -> ignored. The next frame uses the mode sampled in IDLE.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared definitions for the commutator-buffer sequencer.
//   CB_NSEG       default number of buffer segments
//   CB_SEL_SHIFT  select code: every segment takes the value of the segment above
//   CB_SEL_LOAD0  select code for loading lane D0; lane k is CB_SEL_LOAD0 + k
//   cb_state_e    sequencer state encoding
package cb_pkg;

    localparam int unsigned CB_NSEG      = 8;
    localparam int unsigned CB_SEL_SHIFT = 0;
    localparam int unsigned CB_SEL_LOAD0 = 1;

    typedef enum logic [2:0] {
        CB_IDLE   = 3'd0,
        CB_GATHER = 3'd1,
        CB_GFULL  = 3'd2,
        CB_SLOAD  = 3'd3,
        CB_SSHIFT = 3'd4
    } cb_state_e;

endpackage

// File: rtl/cb_hold_decoder.sv
// Active-low one-hot hold decoder.
//   cnt   segment index to release
//   en    release enable; when 0 every segment is held
//   hold  per-segment hold, 1 = segment keeps its value
module cb_hold_decoder #(
    parameter int unsigned NSEG  = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    output logic [NSEG-1:0]  hold
);

    // Release exactly one segment when enabled.
    always_comb begin
        hold = '1;
        if (en) begin
            hold[cnt] = 1'b0;
        end
    end

endmodule

// File: rtl/cb_circuit_ctrl.sv
// Sequencer for the segmented commutator buffer of the FFT datapath.
// GATHER (mode 0): eight serial words on lane D0 become one frame on Q0..Q7.
// SCATTER (mode 1): one frame on D0..D7 leaves as eight serial words on Q0.
//   clk, rst             clock, asynchronous active-high reset
//   mode                 0 = gather, 1 = scatter; sampled only while idle
//   in_valid, in_ready   upstream handshake
//   out_valid, out_ready downstream handshake; data is the buffer's Q outputs
//   out_last             last beat of the frame
//   hold_seg             per-segment hold into the buffer (1 = keep)
//   seg_sel              shared segment select into the buffer
//   busy                 sequencer not idle
// The buffer enables are same-cycle controls, so outputs decode
// combinationally from state, cnt and the handshake inputs.
module cb_circuit_ctrl
    import cb_pkg::*;
#(
    parameter int unsigned NSEG  = CB_NSEG,
    parameter int unsigned SEL_W = $clog2(NSEG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [NSEG-1:0]  hold_seg,
    output logic [SEL_W-1:0] seg_sel,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(NSEG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSEG - 1);

    cb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             dec_en;
    logic [NSEG-1:0]  dec_hold;

    cb_hold_decoder #(
        .NSEG  (NSEG),
        .CNT_W (CNT_W)
    ) u_hold_dec (
        .cnt  (cnt_q),
        .en   (dec_en),
        .hold (dec_hold)
    );

    // State, beat counter and latched mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CB_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next state and buffer/handshake decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dec_en    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        seg_sel   = SEL_W'(CB_SEL_SHIFT);
        hold_seg  = dec_hold;
        busy      = (state_q != CB_IDLE);

        case (state_q)
            CB_IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = mode ? CB_SLOAD : CB_GATHER;
                end
            end

            CB_GATHER: begin
                in_ready = 1'b1;
                seg_sel  = SEL_W'(CB_SEL_LOAD0);
                dec_en   = in_valid;
                if (in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = CB_GFULL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            CB_GFULL: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = CB_IDLE;
                end
            end

            // One frame beat is written one lane per cycle; it is only
            // accepted once the last lane is being written.
            CB_SLOAD: begin
                in_ready = (cnt_q == CNT_LAST);
                seg_sel  = SEL_W'(cnt_q) + SEL_W'(CB_SEL_LOAD0);
                dec_en   = in_valid;
                if (in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = CB_SSHIFT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Whole buffer shifts toward segment 0 on each accepted word.
            CB_SSHIFT: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == CNT_LAST);
                hold_seg  = {NSEG{~out_ready}};
                if (out_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = CB_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = CB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cb_circuit_ctrl.sv
// Bench for cb_circuit_ctrl: a behavioural 8-segment buffer driven by the
// sequencer's controls, frame-level scoreboard, directed and random frames.
module tb_cb_circuit_ctrl;
    import cb_pkg::*;

    localparam int unsigned NSEG  = CB_NSEG;
    localparam int unsigned SEL_W = $clog2(NSEG + 1);

    typedef struct packed {
        logic        m;
        logic [63:0] w;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [NSEG-1:0]  hold_seg;
    logic [SEL_W-1:0] seg_sel;
    logic             busy;

    logic [7:0] d [NSEG];
    logic [7:0] q [NSEG+1];   // q[NSEG] is the constant zero fed into the top segment

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    bit     chk_en = 1'b0;
    bit     in_phase = 1'b0;
    bit     cur_mode = 1'b0;
    bit     rdy_rand = 1'b0;
    bit     rdy_dir = 1'b1;

    always #5 clk = ~clk;

    cb_circuit_ctrl #(.NSEG(NSEG), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .hold_seg  (hold_seg),
        .seg_sel   (seg_sel),
        .busy      (busy)
    );

    // Behavioural commutator buffer.
    always @(posedge clk) begin
        for (int k = 0; k < NSEG; k++) begin
            if (!hold_seg[k]) begin
                if (seg_sel == 0) q[k] <= q[k+1];
                else if (int'(seg_sel) <= NSEG) q[k] <= d[int'(seg_sel) - 1];
            end
        end
    end

    function automatic logic [63:0] qpack();
        logic [63:0] r;
        for (int k = 0; k < NSEG; k++) r[k*8 +: 8] = q[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: random or directed, applied after the driver settles.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? (($urandom % 3) != 0) : rdy_dir;
        end
    end

    // Compare process: protocol rules and frame scoreboard, every cycle.
    initial begin
        int          widx = 0;
        int          vcnt = 0;
        bit          zero_pending = 1'b0;
        bit          stall_pending = 1'b0;
        bit          prev_phase = 1'b0;
        logic [63:0] snap;
        frame_t      f;
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("sel_range", 64'(int'(seg_sel) <= NSEG), 64'(1));
                if (!out_valid) chk("hold_onehot", 64'($countones(~hold_seg) <= 1), 64'(1));
                if (out_valid && !out_ready) chk("bp_hold", 64'(hold_seg), 64'(8'hFF));
                if (!busy) begin
                    chk("idle_in_ready", 64'(in_ready), 64'(0));
                    chk("idle_out_valid", 64'(out_valid), 64'(0));
                end
                if (stall_pending && out_valid) chk("bp_stable", qpack(), snap);
                stall_pending = out_valid && !out_ready;
                snap = qpack();
                if (in_phase && !prev_phase) vcnt = 0;
                prev_phase = in_phase;
                if (in_phase) begin
                    chk("phase_busy", 64'(busy), 64'(1));
                    if (!in_valid) chk("gap_hold", 64'(hold_seg), 64'(8'hFF));
                    if (cur_mode) begin
                        chk("sload_in_ready", 64'(in_ready), 64'(vcnt == 7));
                        if (in_valid) vcnt++;
                    end else begin
                        chk("gather_in_ready", 64'(in_ready), 64'(1));
                    end
                end
                if (zero_pending) begin
                    chk("scatter_zero", qpack(), 64'(0));
                    zero_pending = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(1), 64'(0));
                    end else begin
                        f = exp_q[0];
                        if (!f.m) begin
                            chk("gather_frame", qpack(), f.w);
                            chk("gather_last", 64'(out_last), 64'(1));
                            void'(exp_q.pop_front());
                        end else begin
                            chk("scatter_word", 64'(q[0]), 64'(f.w[widx*8 +: 8]));
                            chk("scatter_last", 64'(out_last), 64'(widx == 7));
                            widx++;
                            if (widx == NSEG) begin
                                widx = 0;
                                zero_pending = 1'b1;
                                void'(exp_q.pop_front());
                            end
                        end
                    end
                end
            end else begin
                widx = 0;
                zero_pending = 1'b0;
                stall_pending = 1'b0;
                prev_phase = 1'b0;
            end
        end
    end

    // Start a frame from idle and present it until fully accepted.
    task automatic send_frame(input logic m, input logic [63:0] w, input logic [7:0] gap_mask,
                              input bit rnd_valid);
        frame_t f;
        int     t;
        int     idx;
        int     nb;
        bit     gap_done;
        bit     acc;
        t = 0;
        while (busy && t < 300) begin
            mode = 1'($urandom);
            @(posedge clk); #1;
            t++;
        end
        if (busy) chk("idle_timeout", 64'(1), 64'(0));
        f.m = m;
        f.w = w;
        exp_q.push_back(f);
        mode     = m;
        in_valid = 1'b1;
        for (int k = 0; k < NSEG; k++) d[k] = m ? w[k*8 +: 8] : 8'h00;
        if (!m) d[0] = w[7:0];
        @(posedge clk); #1;
        cur_mode = m;
        in_phase = 1'b1;
        idx = 0;
        nb = m ? 1 : NSEG;
        gap_done = 1'b0;
        t = 0;
        while (idx < nb && t < 500) begin
            mode = 1'($urandom);
            if (!m) d[0] = w[idx*8 +: 8];
            in_valid = !(gap_mask[idx] && !gap_done) && (!rnd_valid || ($urandom % 4) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            t++;
            if (!in_valid) gap_done = 1'b1;
            if (acc) begin
                idx++;
                gap_done = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_phase = 1'b0;
        if (idx < nb) chk("accept_timeout", 64'(idx), 64'(nb));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy || exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < NSEG; k++) d[k] = 8'h00;
        for (int k = 0; k <= NSEG; k++) q[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", 64'(hold_seg), 64'(8'hFF));
        chk("rst_sel", 64'(seg_sel), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Gather 0..7, no gaps.
        send_frame(1'b0, 64'h0706050403020100, 8'h00, 1'b0);
        @(negedge clk);
        chk("g1_frame", qpack(), 64'h0706050403020100);
        chk("g1_valid_last", 64'({out_valid, out_last}), 64'(2'b11));
        @(posedge clk); #1;
        chk("g1_busy_fall", 64'(busy), 64'(0));

        // Gather with in_valid dropped on beats 2 and 5.
        send_frame(1'b0, 64'h0706050403020100, 8'b0010_0100, 1'b0);
        @(negedge clk);
        chk("g2_frame", qpack(), 64'h0706050403020100);
        wait_idle();

        // Scatter A0..A7 with 3 stall cycles on word A2.
        send_frame(1'b1, 64'hA7A6A5A4A3A2A1A0, 8'h00, 1'b0);
        @(negedge clk);
        chk("s1_w0", 64'(q[0]), 64'(8'hA0));
        @(negedge clk);
        chk("s1_w1", 64'(q[0]), 64'(8'hA1));
        @(posedge clk); #1;
        rdy_dir = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("s1_stall_q0", 64'(q[0]), 64'(8'hA2));
            chk("s1_stall_hold", 64'(hold_seg), 64'(8'hFF));
            chk("s1_stall_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        rdy_dir = 1'b1;
        wait_idle();
        chk("s1_zero", qpack(), 64'(0));

        // Reset in the middle of a scatter shift, cnt = 4.
        send_frame(1'b1, 64'h1716151413121110, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_q0", 64'(q[0]), 64'(8'h14));
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_hold", 64'(hold_seg), 64'(8'hFF));
        chk("mid_rst_sel", 64'(seg_sel), 64'(0));
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk_en = 1'b1;

        // Random frames, random gaps and backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_frame(1'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b1);
        end
        wait_idle();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
